// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoder outputs and control toward the stage, EX register contents back.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              hold;
  logic              flush;
  logic              id_regDst, id_jump, id_branch, id_memRead;
  logic              id_memToReg, id_regWrite, id_ALUSrc, id_memWrite;
  logic [2:0]        id_ALUop;
  logic [4:0]        id_rs, id_rt, id_rd;
  logic [DATA_W-1:0] id_rdata1, id_rdata2, id_imm, id_pc4;

  logic              stall;
  logic              ex_valid;
  logic              ex_jump, ex_branch, ex_memRead, ex_memToReg;
  logic              ex_regWrite, ex_ALUSrc, ex_memWrite;
  logic [2:0]        ex_ALUop;
  logic [4:0]        ex_rs, ex_rt, ex_dst;
  logic [DATA_W-1:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output hold, flush,
    output id_regDst, id_jump, id_branch, id_memRead,
    output id_memToReg, id_regWrite, id_ALUSrc, id_memWrite,
    output id_ALUop, id_rs, id_rt, id_rd,
    output id_rdata1, id_rdata2, id_imm, id_pc4,
    input  stall, ex_valid,
    input  ex_jump, ex_branch, ex_memRead, ex_memToReg,
    input  ex_regWrite, ex_ALUSrc, ex_memWrite,
    input  ex_ALUop, ex_rs, ex_rt, ex_dst,
    input  ex_rdata1, ex_rdata2, ex_imm, ex_pc4,
    input  bubble_cnt
  );

  modport slave (
    input  hold, flush,
    input  id_regDst, id_jump, id_branch, id_memRead,
    input  id_memToReg, id_regWrite, id_ALUSrc, id_memWrite,
    input  id_ALUop, id_rs, id_rt, id_rd,
    input  id_rdata1, id_rdata2, id_imm, id_pc4,
    output stall, ex_valid,
    output ex_jump, ex_branch, ex_memRead, ex_memToReg,
    output ex_regWrite, ex_ALUSrc, ex_memWrite,
    output ex_ALUop, ex_rs, ex_rt, ex_dst,
    output ex_rdata1, ex_rdata2, ex_imm, ex_pc4,
    output bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and a saturating bubble counter.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  bus
);

  // Unknown control bits collapse to 0 so EX never sees X control.
  function automatic logic ctl_bit(input logic b);
    return (b === 1'b1);
  endfunction

  function automatic logic [2:0] ctl_op(input logic [2:0] v);
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = ctl_bit(v[i]);
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic       hazard;
  logic [4:0] dst;

  assign hazard = bus.ex_valid & bus.ex_memRead & (bus.ex_rt != 5'd0) &
                  ((bus.ex_rt == bus.id_rs) | (bus.ex_rt == bus.id_rt));
  assign bus.stall = hazard & ~bus.flush & ~bus.hold;
  assign dst = ctl_bit(bus.id_regDst) ? bus.id_rd : bus.id_rt;

  // ID -> EX register boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ex_valid    <= 1'b0;
      bus.ex_jump     <= 1'b0;
      bus.ex_branch   <= 1'b0;
      bus.ex_memRead  <= 1'b0;
      bus.ex_memToReg <= 1'b0;
      bus.ex_regWrite <= 1'b0;
      bus.ex_ALUSrc   <= 1'b0;
      bus.ex_memWrite <= 1'b0;
      bus.ex_ALUop    <= 3'd0;
      bus.ex_rs       <= 5'd0;
      bus.ex_rt       <= 5'd0;
      bus.ex_dst      <= 5'd0;
      bus.ex_rdata1   <= '0;
      bus.ex_rdata2   <= '0;
      bus.ex_imm      <= '0;
      bus.ex_pc4      <= '0;
      bus.bubble_cnt  <= '0;
    end else if (bus.hold) begin
      // Memory wait freezes the whole stage, including the counter.
    end else if (bus.flush || hazard) begin
      bus.ex_valid    <= 1'b0;
      bus.ex_jump     <= 1'b0;
      bus.ex_branch   <= 1'b0;
      bus.ex_memRead  <= 1'b0;
      bus.ex_memToReg <= 1'b0;
      bus.ex_regWrite <= 1'b0;
      bus.ex_ALUSrc   <= 1'b0;
      bus.ex_memWrite <= 1'b0;
      bus.ex_ALUop    <= 3'd0;
      if (!bus.flush) bus.bubble_cnt <= sat_inc(bus.bubble_cnt);
    end else begin
      bus.ex_valid    <= 1'b1;
      bus.ex_jump     <= ctl_bit(bus.id_jump);
      bus.ex_branch   <= ctl_bit(bus.id_branch);
      bus.ex_memRead  <= ctl_bit(bus.id_memRead);
      bus.ex_memToReg <= ctl_bit(bus.id_memToReg);
      bus.ex_regWrite <= ctl_bit(bus.id_regWrite);
      bus.ex_ALUSrc   <= ctl_bit(bus.id_ALUSrc);
      bus.ex_memWrite <= ctl_bit(bus.id_memWrite);
      bus.ex_ALUop    <= ctl_op(bus.id_ALUop);
      bus.ex_rs       <= bus.id_rs;
      bus.ex_rt       <= bus.id_rt;
      bus.ex_dst      <= dst;
      bus.ex_rdata1   <= bus.id_rdata1;
      bus.ex_rdata2   <= bus.id_rdata2;
      bus.ex_imm      <= bus.id_imm;
      bus.ex_pc4      <= bus.id_pc4;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: forwarding of fields, load-use bubbles, flush, hold, X control, reset, counter saturation.
module tb_id_ex_stage;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 3;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_bad;

  id_ex_stage_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic regdst, input logic memrd, input logic alusrc,
                       input logic [2:0] op, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm, input logic [31:0] pc);
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_rd       = rd;
    bus.id_regDst   = regdst;
    bus.id_memRead  = memrd;
    bus.id_memToReg = memrd;
    bus.id_regWrite = 1'b1;
    bus.id_ALUSrc   = alusrc;
    bus.id_memWrite = 1'b0;
    bus.id_jump     = 1'b0;
    bus.id_branch   = 1'b0;
    bus.id_ALUop    = op;
    bus.id_rdata1   = d1;
    bus.id_rdata2   = d2;
    bus.id_imm      = imm;
    bus.id_pc4      = pc;
  endtask

  // LW $8 then a dependent ADD: one hazard bubble, then the ADD loads.
  task automatic do_hazard();
    drive(5'd1, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 3'd0, 32'd1, 32'd2, 32'd4, 32'd100);
    step();
    drive(5'd8, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0, 3'd2, 32'd3, 32'd4, 32'd0, 32'd104);
    step();
    step();
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.hold  = 1'b0;
    bus.flush = 1'b0;
    drive(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 3'd2, 32'd10, 32'd20, 32'd0, 32'd4);
    #3;
    check("rst_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("rst_cnt", {29'd0, bus.bubble_cnt}, 32'd0);
    check("rst_stall", {31'd0, bus.stall}, 32'd0);
    check("rst_regwrite", {31'd0, bus.ex_regWrite}, 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // ADD then dependent ADD
    step();
    check("add_valid", {31'd0, bus.ex_valid}, 32'd1);
    check("add_dst", {27'd0, bus.ex_dst}, 32'd3);
    check("add_rdata1", bus.ex_rdata1, 32'd10);
    check("add_rdata2", bus.ex_rdata2, 32'd20);
    check("add_aluop", {29'd0, bus.ex_ALUop}, 32'd2);
    check("add_pc4", bus.ex_pc4, 32'd4);
    drive(5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, 3'd2, 32'd30, 32'd40, 32'd0, 32'd8);
    #1;
    check("add2_stall", {31'd0, bus.stall}, 32'd0);
    step();
    check("add2_dst", {27'd0, bus.ex_dst}, 32'd5);
    check("add2_rs", {27'd0, bus.ex_rs}, 32'd3);
    check("add2_cnt", {29'd0, bus.bubble_cnt}, 32'd0);

    // LW $t0 then ADD rs=8
    drive(5'd1, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 3'd0, 32'd1, 32'd2, 32'd16, 32'd12);
    #1;
    check("lw_stall_pre", {31'd0, bus.stall}, 32'd0);
    step();
    check("lw_memread", {31'd0, bus.ex_memRead}, 32'd1);
    check("lw_dst", {27'd0, bus.ex_dst}, 32'd8);
    drive(5'd8, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0, 3'd2, 32'd5, 32'd6, 32'd0, 32'd16);
    #1;
    check("lu_stall", {31'd0, bus.stall}, 32'd1);
    step();
    check("bub_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("bub_memread", {31'd0, bus.ex_memRead}, 32'd0);
    check("bub_regwrite", {31'd0, bus.ex_regWrite}, 32'd0);
    check("bub_aluop", {29'd0, bus.ex_ALUop}, 32'd0);
    check("bub_cnt", {29'd0, bus.bubble_cnt}, 32'd1);
    check("bub_stall", {31'd0, bus.stall}, 32'd0);
    step();
    check("lu_add_valid", {31'd0, bus.ex_valid}, 32'd1);
    check("lu_add_dst", {27'd0, bus.ex_dst}, 32'd10);
    check("lu_add_rs", {27'd0, bus.ex_rs}, 32'd8);
    check("lu_add_cnt", {29'd0, bus.bubble_cnt}, 32'd1);

    // LW rt=0 then ADD rs=0
    drive(5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 3'd0, 32'd1, 32'd2, 32'd8, 32'd20);
    step();
    drive(5'd0, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 3'd2, 32'd0, 32'd2, 32'd0, 32'd24);
    #1;
    check("r0_stall", {31'd0, bus.stall}, 32'd0);
    step();
    check("r0_valid", {31'd0, bus.ex_valid}, 32'd1);
    check("r0_cnt", {29'd0, bus.bubble_cnt}, 32'd1);

    // flush together with a load-use hazard
    drive(5'd1, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 3'd0, 32'd1, 32'd2, 32'd4, 32'd28);
    step();
    drive(5'd8, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0, 3'd2, 32'd1, 32'd2, 32'd0, 32'd32);
    bus.flush = 1'b1;
    #1;
    check("fl_stall", {31'd0, bus.stall}, 32'd0);
    step();
    check("fl_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("fl_cnt", {29'd0, bus.bubble_cnt}, 32'd1);
    bus.flush = 1'b0;

    // hold for 3 cycles with ADDI pending
    drive(5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 3'd2, 32'd11, 32'd22, 32'd0, 32'd36);
    step();
    check("pre_hold_dst", {27'd0, bus.ex_dst}, 32'd7);
    drive(5'd2, 5'd12, 5'd31, 1'b0, 1'b0, 1'b1, 3'd1, 32'd5, 32'd0, 32'd100, 32'd40);
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_dst", {27'd0, bus.ex_dst}, 32'd7);
      check("hold_valid", {31'd0, bus.ex_valid}, 32'd1);
      check("hold_pc4", bus.ex_pc4, 32'd36);
    end
    bus.hold = 1'b0;
    step();
    check("addi_dst", {27'd0, bus.ex_dst}, 32'd12);
    check("addi_imm", bus.ex_imm, 32'd100);
    check("addi_alusrc", {31'd0, bus.ex_ALUSrc}, 32'd1);

    // hold with flush retains, then flush alone bubbles uncounted
    drive(5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, 3'd2, 32'd0, 32'd0, 32'd0, 32'd44);
    bus.hold  = 1'b1;
    bus.flush = 1'b1;
    step();
    check("hf_dst", {27'd0, bus.ex_dst}, 32'd12);
    check("hf_valid", {31'd0, bus.ex_valid}, 32'd1);
    bus.hold = 1'b0;
    step();
    check("hf_rel_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("hf_rel_cnt", {29'd0, bus.bubble_cnt}, 32'd1);
    bus.flush = 1'b0;

    // X on decoder controls
    drive(5'd6, 5'd14, 5'd15, 1'b0, 1'b0, 1'b0, 3'd3, 32'd0, 32'd0, 32'd0, 32'd48);
    bus.id_regDst = 1'bx;
    bus.id_jump   = 1'bx;
    bus.id_branch = 1'bx;
    bus.id_ALUop  = 3'b1x0;
    step();
    check("x_jump", {31'd0, bus.ex_jump}, 32'd0);
    check("x_branch", {31'd0, bus.ex_branch}, 32'd0);
    check("x_dst", {27'd0, bus.ex_dst}, 32'd14);
    check("x_aluop", {29'd0, bus.ex_ALUop}, 32'd4);

    // bring counter to 5, then async reset between edges
    for (int i = 0; i < 4; i++) do_hazard();
    check("cnt5", {29'd0, bus.bubble_cnt}, 32'd5);
    check("pre_rst_valid", {31'd0, bus.ex_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("arst_cnt", {29'd0, bus.bubble_cnt}, 32'd0);
    check("arst_dst", {27'd0, bus.ex_dst}, 32'd0);
    check("arst_pc4", bus.ex_pc4, 32'd0);
    check("arst_stall", {31'd0, bus.stall}, 32'd0);
    #1;
    rst_n = 1'b1;
    drive(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 3'd2, 32'd9, 32'd9, 32'd0, 32'd52);
    step();
    check("post_rst_dst", {27'd0, bus.ex_dst}, 32'd3);
    check("post_rst_valid", {31'd0, bus.ex_valid}, 32'd1);

    // counter saturation at all-ones
    for (int i = 0; i < 7; i++) do_hazard();
    check("cnt7", {29'd0, bus.bubble_cnt}, 32'd7);
    do_hazard();
    check("cnt_sat", {29'd0, bus.bubble_cnt}, 32'd7);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, width of register-file data, immediate and PC values.
REQ-002 The block SHALL have parameter CNT_W, default 16, width of the bubble counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 hold  input  1  global freeze from memory wait; stage retains contents.
REQ-006 flush  input  1  taken branch or jump resolved downstream; kill the instruction in ID.
REQ-007 id_regDst, id_jump, id_branch, id_memRead, id_memToReg, id_regWrite, id_ALUSrc, id_memWrite  input  1 each  decoder control outputs.
REQ-008 id_ALUop  input  3  decoder ALU operation.
REQ-009 id_rs, id_rt, id_rd  input  5 each  instruction register fields.
REQ-010 id_rdata1, id_rdata2, id_imm, id_pc4  input  DATA_W each  register reads, sign-extended immediate, PC+4.
REQ-011 stall  output  1  combinational; upstream PC and IF/ID register hold while high.
REQ-012 ex_valid  output  1  registered; EX holds a real instruction.
REQ-013 ex_jump, ex_branch, ex_memRead, ex_memToReg, ex_regWrite, ex_ALUSrc, ex_memWrite  output  1 each  registered control.
REQ-014 ex_ALUop  output  3  registered ALU operation.
REQ-015 ex_rs, ex_rt, ex_dst  output  5 each  registered sources and resolved destination.
REQ-016 ex_rdata1, ex_rdata2, ex_imm, ex_pc4  output  DATA_W each  registered datapath values.
REQ-017 bubble_cnt  output  CNT_W  registered count of load-use bubbles inserted.

Function
REQ-018 Load-use hazard SHALL be: ex_valid & ex_memRead & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
REQ-019 stall SHALL equal hazard & ~flush & ~hold.
REQ-020 Destination SHALL be resolved at load: ex_dst = id_regDst ? id_rd : id_rt; an id_regDst of X or 0 selects id_rt.
REQ-021 Per-edge priority SHALL be: hold (retain all registers, counter unchanged) > flush (load bubble) > hazard (load bubble, increment counter) > normal load.
REQ-022 Normal load SHALL capture every id_* input into its ex_* register and set ex_valid = 1; latency is exactly one cycle.
REQ-023 A bubble SHALL clear ex_valid and all control outputs including ex_ALUop to 0; datapath and register-field outputs MAY keep any value.
REQ-024 Any X on a decoder control input SHALL be captured as 0 so EX never receives X control.
REQ-025 bubble_cnt SHALL increment by 1 per hazard bubble and saturate at all-ones; flush bubbles are not counted.
REQ-026 A hazard persists at most one cycle: the bubble clears ex_valid, so the next cycle loads the held instruction.
REQ-027 hold together with flush SHALL retain state; upstream keeps flush asserted until hold drops.
REQ-028 No internal state machine beyond the ex_* registers and counter is required.

Reset
REQ-029 On rst_n low, at once and regardless of clk, all ex_* outputs, ex_valid and bubble_cnt SHALL become 0.
REQ-030 rst_n low mid-operation SHALL discard the instruction in EX; first edge after release performs normal load, bubble or hold per REQ-021.
REQ-031 stall SHALL be 0 while in reset since ex_valid is 0.

Verification
REQ-032 ADD then dependent ADD (no load): ex_* equals id_* one cycle later, stall never 1, bubble_cnt = 0.
REQ-033 LW $t0 (rt=8) then ADD rs=8: stall = 1 for exactly one cycle, ex_valid = 0 next cycle, then ADD loads; bubble_cnt = 1.
REQ-034 LW with rt=0 then ADD rs=0: stall stays 0, no bubble.
REQ-035 flush = 1 together with a load-use hazard: stall = 0, bubble loaded, bubble_cnt unchanged.
REQ-036 hold = 1 for 3 cycles with ADDI pending: ex_* unchanged for 3 edges, then ADDI loads with ex_dst = id_rt.
REQ-037 rst_n pulsed low between edges with ex_valid = 1 and bubble_cnt = 5: outputs 0 immediately, not at next edge.
